morse_decoder: RTL and testbench

Receive-side counterpart to the lab's Morse transmitter. Measures press and release durations on a single push-button and classifies each press as a dot or a dash. Assembles up to four symbols per letter and decodes the letters A–H into the same 3-bit code the transmitter takes on SW[2:0]. Shows the decoded letter on HEX0 and decoder status on LEDR, so the transmitter's LEDR output can be keyed back in by hand to check it.

---
 rtl/morse_pkg.sv | 75 +++++++
 rtl/morse_debounce.sv | 51 +++++
 rtl/morse_decoder.sv | 155 +++++++++++++++
 tb/tb_morse_decoder.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// Shared constants for the Morse receiver: seven-segment glyphs, letter
// codes, the A-H pattern table, timing thresholds and FSM encodings.
package morse_pkg;

  // Active-low seven-segment glyphs, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] BLANK    = 7'b1111111;
  localparam logic [6:0] LETTER_A = 7'b0001000;
  localparam logic [6:0] LETTER_B = 7'b0000011;
  localparam logic [6:0] LETTER_C = 7'b1000110;
  localparam logic [6:0] LETTER_D = 7'b0100001;
  localparam logic [6:0] LETTER_E = 7'b0000110;
  localparam logic [6:0] LETTER_F = 7'b0001110;
  localparam logic [6:0] LETTER_G = 7'b1000010;
  localparam logic [6:0] LETTER_H = 7'b0001001;
  localparam logic [6:0] DASH     = 7'b0111111;

  // Letter codes match the transmitter's SW[2:0] selection
  typedef enum logic [2:0] {
    CODE_A = 3'd0,
    CODE_B = 3'd1,
    CODE_C = 3'd2,
    CODE_D = 3'd3,
    CODE_E = 3'd4,
    CODE_F = 3'd5,
    CODE_G = 3'd6,
    CODE_H = 3'd7
  } letter_code_e;

  // Press length in units at which a symbol becomes a dash
  localparam int DOT_DASH_UNITS   = 2;
  // Silence length in units that closes a letter
  localparam int LETTER_GAP_UNITS = 3;

  // FSM encodings
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_MARK  = 2'd1;
  localparam logic [1:0] ST_SPACE = 2'd2;

  // Symbol i of a letter lives in bit i, 1 = dash
  localparam logic [3:0] LETTER_PATTERN [0:7] = '{
    4'b0010, 4'b0001, 4'b0101, 4'b0001,
    4'b0000, 4'b0100, 4'b0011, 4'b0000
  };
  localparam logic [2:0] LETTER_LENGTH [0:7] = '{
    3'd2, 3'd4, 3'd4, 3'd3, 3'd1, 3'd4, 3'd3, 3'd4
  };
  localparam logic [6:0] LETTER_GLYPH [0:7] = '{
    LETTER_A, LETTER_B, LETTER_C, LETTER_D,
    LETTER_E, LETTER_F, LETTER_G, LETTER_H
  };

  typedef struct packed {
    logic         hit;
    letter_code_e code;
  } lookup_t;

  // Match a symbol buffer and its length against the A-H table
  function automatic lookup_t lookup_letter(input logic [3:0] pattern,
                                            input logic [2:0] length);
    lookup_t    result;
    logic [3:0] mask;
    result.hit  = 1'b0;
    result.code = CODE_A;
    mask = 4'((5'd1 << length) - 5'd1);
    for (int i = 0; i < 8; i++) begin
      if (!result.hit && length == LETTER_LENGTH[i] &&
          (pattern & mask) == (LETTER_PATTERN[i] & mask)) begin
        result.hit  = 1'b1;
        result.code = letter_code_e'(3'(i));
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/morse_debounce.sv
// Key conditioning for the Morse receiver: two-flop synchroniser followed by
// an optional hold-time filter, enabled by defining MORSE_DEBOUNCE_EN.
// Output level is 1 while the key is pressed.
module morse_debounce
  import morse_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic CLOCK_50,
  input  logic rst_n,
  input  logic key_n,
  output logic level
);

  logic [1:0] sync_n;
  logic       pressed;

  // Bring the asynchronous key into the clock domain, idle level is released
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) sync_n <= 2'b11;
    else        sync_n <= {sync_n[0], key_n};
  end

  assign pressed = ~sync_n[1];

`ifdef MORSE_DEBOUNCE_EN
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [DW-1:0] hold_cnt;

  // Accept a new level only after it has been stable for the full hold time
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      level    <= 1'b0;
      hold_cnt <= '0;
    end else if (pressed == level) begin
      hold_cnt <= '0;
    end else if (hold_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
      level    <= pressed;
      hold_cnt <= '0;
    end else begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end
`else
  logic unused_debounce_cfg;
  assign unused_debounce_cfg = (DEBOUNCE_CYCLES != 0);
  assign level = pressed;
`endif

endmodule

// File: rtl/morse_decoder.sv
// Morse receiver: times presses and gaps on KEY[3], classifies dots and
// dashes, decodes letters A-H and shows the result on HEX0 / LEDR.
// Build option: MORSE_DEBOUNCE_EN adds a hold-time filter on the key.
module morse_decoder
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES     = 8388608,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic        CLOCK_50,
  input  logic [3:0]  KEY,
  output logic [6:0]  HEX0,
  output logic [17:0] LEDR
);

  localparam int CW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;

  logic          rst_n;
  logic          mark;
  logic          mark_q;
  logic          rise;
  logic          fall;
  logic [CW-1:0] cycle_cnt;
  logic [2:0]    units;
  logic          unit_step;
  logic [2:0]    units_adv;
  logic          is_dash;
  logic          gap_timeout;
  logic [1:0]    state;
  logic [3:0]    sym_buf;
  logic [2:0]    sym_count;
  logic          overflow;
  logic [2:0]    last_code;
  logic          valid_q;
  logic          error_q;
  logic [6:0]    hex_q;
  lookup_t       match;
  logic          unused_keys;

  assign rst_n       = KEY[0];
  assign unused_keys = ^KEY[2:1];

  morse_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .CLOCK_50(CLOCK_50),
    .rst_n   (rst_n),
    .key_n   (KEY[3]),
    .level   (mark)
  );

  // Delayed copy of the key level for edge strobes
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) mark_q <= 1'b0;
    else        mark_q <= mark;
  end

  assign rise = mark & ~mark_q;
  assign fall = ~mark & mark_q;

  // The unit count including the step happening this cycle lets a press of
  // exactly two units read as two at its falling edge.
  assign unit_step   = (cycle_cnt == CW'(UNIT_CYCLES - 1));
  assign units_adv   = !unit_step ? units : ((units == 3'd7) ? 3'd7 : units + 3'd1);
  assign is_dash     = (units_adv >= 3'(DOT_DASH_UNITS));
  assign gap_timeout = (state == ST_SPACE) && unit_step &&
                       (units == 3'(LETTER_GAP_UNITS - 1));
  assign match       = lookup_letter(sym_buf, sym_count);

  // Duration counters restart on every key edge, units saturate at seven
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt <= '0;
      units     <= 3'd0;
    end else if (rise || fall) begin
      cycle_cnt <= '0;
      units     <= 3'd0;
    end else if (unit_step) begin
      cycle_cnt <= '0;
      units     <= units_adv;
    end else begin
      cycle_cnt <= cycle_cnt + 1'b1;
    end
  end

  // Letter assembly: start on a press, record symbols on release, close on a long gap
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      sym_buf   <= 4'd0;
      sym_count <= 3'd0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rise) begin
            sym_buf   <= 4'd0;
            sym_count <= 3'd0;
            overflow  <= 1'b0;
            state     <= ST_MARK;
          end
        end
        ST_MARK: begin
          if (fall) begin
            if (sym_count == 3'd4) begin
              overflow <= 1'b1;
            end else begin
              sym_buf[sym_count[1:0]] <= is_dash;
              sym_count               <= sym_count + 3'd1;
            end
            state <= ST_SPACE;
          end
        end
        ST_SPACE: begin
          if (rise) begin
            if (gap_timeout) begin
              sym_buf   <= 4'd0;
              sym_count <= 3'd0;
              overflow  <= 1'b0;
            end
            state <= ST_MARK;
          end else if (gap_timeout) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Displayed result changes only when a letter is closed
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      last_code <= 3'd0;
      valid_q   <= 1'b0;
      error_q   <= 1'b0;
      hex_q     <= BLANK;
    end else if (gap_timeout) begin
      if (match.hit && !overflow) begin
        last_code <= match.code;
        valid_q   <= 1'b1;
        error_q   <= 1'b0;
        hex_q     <= LETTER_GLYPH[match.code];
      end else begin
        valid_q   <= 1'b0;
        error_q   <= 1'b1;
        hex_q     <= DASH;
      end
    end
  end

  assign HEX0 = hex_q;
  assign LEDR = {5'd0, error_q | overflow, valid_q, last_code, sym_count, sym_buf, mark};

endmodule

// File: tb/tb_morse_decoder.sv
// Self-checking bench for morse_decoder with short unit and debounce times.
// Key activity is described as press/gap durations; a reference model turns
// those durations into dot/dash strings and looks letters up by name.
module tb_morse_decoder;

  localparam int UNIT = 16;
  localparam int DEB  = 4;
`ifdef MORSE_DEBOUNCE_EN
  localparam int MIN_PRESS = DEB;
`else
  localparam int MIN_PRESS = 1;
`endif

  logic        clk;
  logic [3:0]  key;
  logic [6:0]  hex0;
  logic [17:0] ledr;

  int vectors;
  int miscompares;

  // Reference model state
  string      letter_str [8] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "...."};
  logic [6:0] glyph_ref  [8] = '{7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001,
                                 7'b0000110, 7'b0001110, 7'b1000010, 7'b0001001};
  string      cur;
  bit         in_letter;
  int         m_count;
  logic [3:0] m_buf;
  logic [6:0] exp_hex;
  logic [2:0] exp_code;
  logic       exp_valid;
  logic       exp_error;

  morse_decoder #(
    .UNIT_CYCLES    (UNIT),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .CLOCK_50(clk),
    .KEY     (key),
    .HEX0    (hex0),
    .LEDR    (ledr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [17:0] observed,
                             input logic [17:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    cur       = "";
    in_letter = 0;
    m_count   = 0;
    m_buf     = 4'd0;
    exp_hex   = 7'b1111111;
    exp_code  = 3'd0;
    exp_valid = 1'b0;
    exp_error = 1'b0;
  endtask

  task automatic modelCommit();
    int found;
    found = -1;
    if (cur.len() <= 4)
      for (int i = 0; i < 8; i++)
        if (cur == letter_str[i]) found = i;
    if (found >= 0) begin
      exp_code  = 3'(found);
      exp_valid = 1'b1;
      exp_error = 1'b0;
      exp_hex   = glyph_ref[found];
    end else begin
      exp_valid = 1'b0;
      exp_error = 1'b1;
      exp_hex   = 7'b0111111;
    end
    in_letter = 0;
  endtask

  task automatic modelPress(input int n);
    bit dash;
    if (n < MIN_PRESS) return;
    if (!in_letter) begin
      cur       = "";
      m_count   = 0;
      m_buf     = 4'd0;
      in_letter = 1;
    end
    dash = (n >= 2 * UNIT);
    if (cur.len() < 4) begin
      m_buf[cur.len()] = dash;
      m_count++;
    end
    if (dash) cur = {cur, "-"};
    else      cur = {cur, "."};
  endtask

  task automatic modelGap(input int n);
    if (in_letter && n >= 3 * UNIT) modelCommit();
  endtask

  // Hold the key pressed for press cycles, then released for gap cycles
  task automatic applyStimulus(input int press, input int gap);
    key[3] = 1'b0;
    repeat (press) @(posedge clk);
    #1;
    key[3] = 1'b1;
    repeat (gap) @(posedge clk);
    #1;
    modelPress(press);
    modelGap(gap);
  endtask

  task automatic checkState(input string tag);
    logic overflow_now;
    overflow_now = in_letter && (cur.len() > 4);
    checkOutput({tag, ".hex"},   {11'd0, hex0}, {11'd0, exp_hex});
    checkOutput({tag, ".code"},  {15'd0, ledr[10:8]}, {15'd0, exp_code});
    checkOutput({tag, ".valid"}, {17'd0, ledr[11]}, {17'd0, exp_valid});
    checkOutput({tag, ".error"}, {17'd0, ledr[12]}, {17'd0, exp_error | overflow_now});
    checkOutput({tag, ".status"}, {10'd0, ledr[7:0]},
                {10'd0, 3'(m_count), m_buf, 1'b0});
    checkOutput({tag, ".upper"}, {13'd0, ledr[17:13]}, 18'd0);
  endtask

  initial begin
    string pat;
    vectors     = 0;
    miscompares = 0;
    modelReset();
    key = 4'b1110;
    repeat (3) @(posedge clk);
    #1;
    checkState("reset");
    key[0] = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // Single short press decodes as E
    applyStimulus(16, 60);
    checkState("letter_e");

    // -.-. decodes as C
    applyStimulus(48, 16);
    applyStimulus(16, 16);
    applyStimulus(48, 16);
    checkState("c_midletter");
    applyStimulus(16, 60);
    checkState("letter_c");

    // Press boundary: 32 cycles is a dash, 31 is a dot
    applyStimulus(16, 20);
    applyStimulus(32, 60);
    checkState("press_32_dash");
    applyStimulus(16, 20);
    applyStimulus(31, 60);
    checkState("press_31_dot");

    // Five dots overflow the buffer
    for (int i = 0; i < 5; i++) applyStimulus(16, (i == 4) ? 60 : 20);
    checkState("five_dots");

    // A valid G, then --.- which is outside the set
    applyStimulus(40, 20);
    applyStimulus(40, 20);
    applyStimulus(16, 60);
    checkState("letter_g");
    applyStimulus(40, 20);
    applyStimulus(40, 20);
    applyStimulus(16, 20);
    applyStimulus(40, 60);
    checkState("unknown_pattern");

    // Gap boundary: 47 cycles keeps the letter open, 48 closes it as the key goes down
    applyStimulus(16, 47);
    applyStimulus(16, 20);
    applyStimulus(40, 60);
    checkState("gap_47");
    applyStimulus(16, 48);
    applyStimulus(16, 20);
    applyStimulus(40, 60);
    checkState("gap_48");

    // Long hold is still a dash
    applyStimulus(130, 20);
    applyStimulus(16, 20);
    applyStimulus(16, 60);
    checkState("long_hold");

    // Reset in the middle of a letter aborts it
    applyStimulus(16, 20);
    applyStimulus(40, 20);
    checkState("before_reset");
    key[0] = 1'b0;
    #1;
    modelReset();
    checkState("reset_mid");
    repeat (3) @(posedge clk);
    #1;
    key[0] = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    checkState("after_reset");

    // Short glitches on the key
    for (int i = 0; i < 4; i++) applyStimulus(2, (i == 3) ? 70 : 20);
    checkState("glitches");

    // Randomised letters and junk patterns
    for (int n = 0; n < 16; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        pat = letter_str[$urandom_range(0, 7)];
      end else begin
        pat = "";
        for (int s = $urandom_range(1, 5); s > 0; s--)
          if ($urandom_range(0, 1) == 1) pat = {pat, "-"};
          else                           pat = {pat, "."};
      end
      for (int s = 0; s < pat.len(); s++) begin
        int press;
        int gap;
        if (pat[s] == "-") press = int'($urandom_range(32, 75));
        else               press = int'($urandom_range(8, 31));
        gap = (s == pat.len() - 1) ? 70 : int'($urandom_range(8, 40));
        applyStimulus(press, gap);
      end
      checkState($sformatf("random_%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
